btle_tx_pdu_loader: RTL

//  Master side of the btle_phy baremetal TX interface (driven while baremetal_phy_intf_mode=1).

---
 rtl/btle_pkg.sv | 22 ++
 rtl/btle_tx_pdu_loader_if.sv | 30 +++
 rtl/btle_tx_pdu_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/btle_pkg.sv
// Shared btle types and constants.
// Used by the PHY-side TX loader and the PHY itself.
package btle_pkg;

  localparam int CRC_STATE_BIT_WIDTH_DEF = 24;
  localparam int CHANNEL_NUMBER_BIT_WIDTH_DEF = 6;

  // Header length field: octet 1, bits [5:0]
  localparam int HDR_LEN_OCTET = 1;
  localparam int HDR_LEN_MSB = 5;
  localparam int HDR_LEN_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    CFG,
    START,
    WAIT
  } state_t;

endpackage

// File: rtl/btle_tx_pdu_loader_if.sv
// Host-side request and PDU octet stream.
// master = host sequencer, slave = loader.
interface btle_tx_pdu_loader_if;

  logic       req_valid;
  logic       req_ready;
  logic [7:0] s_octet_data;
  logic       s_octet_valid;
  logic       s_octet_ready;
  logic       s_octet_last;

  modport master (
    output req_valid,
    input  req_ready,
    output s_octet_data,
    output s_octet_valid,
    input  s_octet_ready,
    output s_octet_last
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  s_octet_data,
    input  s_octet_valid,
    output s_octet_ready,
    input  s_octet_last
  );

endinterface

// File: rtl/btle_tx_pdu_loader.sv
// Loads one PDU into the btle_phy TX memory,
// starts the PHY and waits for the IQ burst end.
module btle_tx_pdu_loader
  import btle_pkg::*;
#(
  parameter int CRC_STATE_BIT_WIDTH = CRC_STATE_BIT_WIDTH_DEF,
  parameter int CHANNEL_NUMBER_BIT_WIDTH = CHANNEL_NUMBER_BIT_WIDTH_DEF,
  parameter int MAX_PDU_OCTETS = 39,
  parameter int TX_TIMEOUT_CYCLES = 8192
) (
  input  logic clk,
  input  logic rst,

  input  logic [7:0]  cfg_preamble,
  input  logic [31:0] cfg_access_address,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] cfg_crc_init,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cfg_channel,

  btle_tx_pdu_loader_if.slave bus,

  output logic [7:0]  tx_preamble,
  output logic [31:0] tx_access_address,
  output logic [CRC_STATE_BIT_WIDTH-1:0] tx_crc_state_init_bit,
  output logic tx_crc_state_init_bit_load,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
  output logic tx_channel_number_load,
  output logic [7:0] tx_pdu_octet_mem_data,
  output logic [5:0] tx_pdu_octet_mem_addr,
  output logic tx_start,
  input  logic tx_iq_valid_last,

  output logic busy,
  output logic done,
  output logic err_len,
  output logic err_timeout
);

  localparam int TW = $clog2(TX_TIMEOUT_CYCLES);
  localparam logic [6:0] MAX_CNT = 7'(MAX_PDU_OCTETS);
  localparam logic [6:0] HDR_CNT = 7'(HDR_LEN_OCTET);
  localparam logic [TW-1:0] TMO_END = TW'(TX_TIMEOUT_CYCLES - 2);

  state_t state, state_nxt;

  logic [6:0]    cnt;
  logic [5:0]    hdr_len;
  logic          ovf;
  logic [TW-1:0] tmo;

  logic oct_fire;
  logic len_ok;
  logic done_nxt;
  logic err_len_nxt;
  logic err_tmo_nxt;

  assign oct_fire = bus.s_octet_valid && bus.s_octet_ready;

  assign len_ok = !ovf && (cnt >= 7'd2) &&
                  (cnt == ({1'b0, hdr_len} + 7'd2));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, handshakes and PHY strobes
  always_comb begin
    state_nxt = state;
    bus.req_ready = 1'b0;
    bus.s_octet_ready = 1'b0;
    tx_crc_state_init_bit_load = 1'b0;
    tx_channel_number_load = 1'b0;
    tx_start = 1'b0;
    done_nxt = 1'b0;
    err_len_nxt = 1'b0;
    err_tmo_nxt = 1'b0;
    busy = (state != IDLE);
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = LOAD;
      end
      LOAD: begin
        bus.s_octet_ready = 1'b1;
        if (bus.s_octet_valid && bus.s_octet_last)
          state_nxt = CHECK;
      end
      CHECK: begin
        if (len_ok) begin
          state_nxt = CFG;
        end else begin
          err_len_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      CFG: begin
        tx_crc_state_init_bit_load = 1'b1;
        tx_channel_number_load = 1'b1;
        state_nxt = START;
      end
      START: begin
        tx_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_iq_valid_last) begin
          done_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (tmo == TMO_END) begin
          err_tmo_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config capture on request accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_preamble <= '0;
      tx_access_address <= '0;
      tx_crc_state_init_bit <= '0;
      tx_channel_number <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      tx_preamble <= cfg_preamble;
      tx_access_address <= cfg_access_address;
      tx_crc_state_init_bit <= cfg_crc_init;
      tx_channel_number <= cfg_channel;
    end
  end

  // Octet counter, memory write port, length/overflow tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      hdr_len <= '0;
      ovf <= 1'b0;
      tx_pdu_octet_mem_addr <= '0;
      tx_pdu_octet_mem_data <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      cnt <= '0;
      hdr_len <= '0;
      ovf <= 1'b0;
    end else if (oct_fire) begin
      if (cnt < MAX_CNT) begin
        tx_pdu_octet_mem_addr <= cnt[5:0];
        tx_pdu_octet_mem_data <= bus.s_octet_data;
        cnt <= cnt + 7'd1;
        if (cnt == HDR_CNT)
          hdr_len <= bus.s_octet_data[HDR_LEN_MSB:HDR_LEN_LSB];
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  // TX timeout counter, cleared as tx_start fires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tmo <= '0;
    else if (state == START) tmo <= '0;
    else if (state == WAIT)  tmo <= tmo + TW'(1);
  end

  // Status pulses land with the return to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      err_len <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= done_nxt;
      err_len <= err_len_nxt;
      err_timeout <= err_tmo_nxt;
    end
  end

endmodule
